// File: rtl/mem_chk_pkg.sv
// Shared types and helpers for the RAM readback signature checker.
// Optional address-pattern checking is enabled by MEM_CHK_PATTERN_EN.
package mem_chk_pkg;
   localparam int SIG_W  = 32;
   localparam int ADDR_W = 32;

   localparam logic [31:0] NO_MISMATCH = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Rotate left by one, then fold in the (already zero-extended) word.
   function automatic logic [SIG_W-1:0] sig_step(input logic [SIG_W-1:0] sig,
                                                 input logic [SIG_W-1:0] word);
      return {sig[SIG_W-2:0], sig[SIG_W-1]} ^ word;
   endfunction
endpackage

// File: rtl/mem_readback_checker_if.sv
// Host/RAM-facing bundle of the readback checker; master is the checker side.
// MEM_CHK_PATTERN_EN adds the mismatch_count/first_mismatch_addr signals.
interface mem_readback_checker_if #(
   parameter int WID_MEM = 8
) ();
   import mem_chk_pkg::*;

   logic                start;
   logic [ADDR_W-1:0]   raddr;
   logic [WID_MEM-1:0]  dout;
   logic                busy;
   logic                done;
   logic [SIG_W-1:0]    signature;
   logic [31:0]         word_count;

`ifdef MEM_CHK_PATTERN_EN
   logic [31:0]         mismatch_count;
   logic [31:0]         first_mismatch_addr;

   modport master (
      input  start, dout,
      output raddr, busy, done, signature, word_count,
             mismatch_count, first_mismatch_addr
   );
   modport slave (
      output start, dout,
      input  raddr, busy, done, signature, word_count,
             mismatch_count, first_mismatch_addr
   );
`else
   modport master (
      input  start, dout,
      output raddr, busy, done, signature, word_count
   );
   modport slave (
      output start, dout,
      input  raddr, busy, done, signature, word_count
   );
`endif
endinterface

// File: rtl/mem_chk_accum.sv
// Read-valid pipeline plus signature/word_count (and, with MEM_CHK_PATTERN_EN, mismatch) registers.
// Latency: a word issued at an edge is folded RD_LAT edges later; no backpressure, dout is consumed when valid.
module mem_chk_accum
   import mem_chk_pkg::*;
#(
   parameter int WID_MEM = 8,
   parameter int RD_LAT  = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clr,
   input  logic               issue,
   input  logic [WID_MEM-1:0] dout,
   output logic               drained,
   output logic [SIG_W-1:0]   signature,
   output logic [31:0]        word_count
`ifdef MEM_CHK_PATTERN_EN
   ,
   output logic [31:0]        mismatch_count,
   output logic [31:0]        first_mismatch_addr
`endif
);
   // Every pipe stage except the output stage.
   localparam logic [RD_LAT-1:0] REST_MASK = RD_LAT'((1 << (RD_LAT - 1)) - 1);

   logic [RD_LAT-1:0] vld_pipe;
   logic              vld_out;

   assign vld_out = vld_pipe[RD_LAT-1];
   // True when at most the output stage still holds a word: the sweep ends this edge.
   assign drained = (vld_pipe & REST_MASK) == '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_pipe   <= '0;
         signature  <= '0;
         word_count <= '0;
`ifdef MEM_CHK_PATTERN_EN
         mismatch_count      <= '0;
         first_mismatch_addr <= '0;
`endif
      end else if (clr) begin
         vld_pipe   <= '0;
         signature  <= '0;
         word_count <= '0;
`ifdef MEM_CHK_PATTERN_EN
         mismatch_count      <= '0;
         first_mismatch_addr <= NO_MISMATCH;
`endif
      end else begin
         vld_pipe <= RD_LAT'({vld_pipe, issue});
         if (vld_out) begin
            signature  <= sig_step(signature, SIG_W'(dout));
            word_count <= word_count + 32'd1;
`ifdef MEM_CHK_PATTERN_EN
            // Words arrive in address order, so word_count is this word's address.
            if (dout != word_count[WID_MEM-1:0]) begin
               mismatch_count <= mismatch_count + 32'd1;
               if (mismatch_count == '0) begin
                  first_mismatch_addr <= word_count;
               end
            end
`endif
         end
      end
   end
endmodule

// File: rtl/mem_readback_checker.sv
// Sweeps RAM addresses 0..DEPTH_MEM-1 and folds each read word into a 32-bit signature.
// Done rises DEPTH_MEM+RD_LAT edges after an accepted start; start is ignored while busy. Option: MEM_CHK_PATTERN_EN.
module mem_readback_checker
   import mem_chk_pkg::*;
#(
   parameter int WID_MEM   = 8,
   parameter int DEPTH_MEM = 2048,
   parameter int RD_LAT    = 1
) (
   input  logic clk,
   input  logic reset,
   mem_readback_checker_if.master bus
);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_MEM - 1);

   state_t            state;
   logic [ADDR_W-1:0] raddr;
   logic              busy;
   logic              done;
   logic              clr;
   logic              issue;
   logic              drained;

   assign clr   = (state == IDLE) && bus.start;
   assign issue = (state == READ);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         raddr <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state <= READ;
                  raddr <= '0;
                  busy  <= 1'b1;
                  done  <= 1'b0;
               end
            end
            READ: begin
               // The last address is issued this edge; raddr then holds.
               if (raddr == LAST_ADDR) begin
                  state <= DRAIN;
               end else begin
                  raddr <= raddr + 1'b1;
               end
            end
            DRAIN: begin
               if (drained) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   mem_chk_accum #(
      .WID_MEM (WID_MEM),
      .RD_LAT  (RD_LAT)
   ) u_accum (
      .clk        (clk),
      .reset      (reset),
      .clr        (clr),
      .issue      (issue),
      .dout       (bus.dout),
      .drained    (drained),
      .signature  (bus.signature),
      .word_count (bus.word_count)
`ifdef MEM_CHK_PATTERN_EN
      ,
      .mismatch_count      (bus.mismatch_count),
      .first_mismatch_addr (bus.first_mismatch_addr)
`endif
   );

   assign bus.raddr = raddr;
   assign bus.busy  = busy;
   assign bus.done  = done;
endmodule
